// File: rtl/param_data_memory_if.sv
// Request/response bundle between the MEM stage and the data memory.
interface param_data_memory_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                      read_en;
    logic                      write_en;
    logic [ADDR_WIDTH-1:0]     address;
    logic [DATA_WIDTH-1:0]     write_data;
    logic [DATA_WIDTH/8-1:0]   byte_en;
    logic [DATA_WIDTH-1:0]     read_data;
    logic                      ready;
    logic                      addr_error;

    modport master (
        output read_en, write_en, address, write_data, byte_en,
        input  read_data, ready, addr_error
    );

    modport slave (
        input  read_en, write_en, address, write_data, byte_en,
        output read_data, ready, addr_error
    );
endinterface

// File: rtl/param_data_memory.sv
// Multi-cycle data memory: post-reset clearing sweep, fixed wait states,
// byte-lane writes and bad-address reporting behind a ready handshake.
module param_data_memory #(
    parameter int unsigned     DATA_WIDTH  = 32,
    parameter int unsigned     ADDR_WIDTH  = 32,
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter longint unsigned BASE_ADDR   = 1024,
    parameter int unsigned     WAIT_CYCLES = 2
) (
    input logic                clk,
    input logic                rst_n,
    param_data_memory_if.slave bus
);
    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(BYTES);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned WAIT_W = $clog2(WAIT_CYCLES + 1);

    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH_WORDS);

    typedef enum logic [1:0] {StInit, StIdle, StBusy, StDone} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    op_write_q, op_write_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]        ben_q, ben_d;
    logic [DATA_WIDTH-1:0]   read_data_q;
    logic                    addr_error_q;
    logic                    ready;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

    logic [ADDR_WIDTH-1:0]   offset;
    logic [ADDR_WIDTH-1:0]   word_off;
    logic                    bad_addr;
    logic                    request;
    logic                    access;

    // Address decode; the subtraction wraps at ADDR_WIDTH, so below-base is checked separately.
    always_comb begin
        offset   = bus.address - BASE;
        word_off = offset >> LSB;
        bad_addr = (bus.address < BASE) || (word_off >= DEPTH_A)
                   || ((bus.address & ALIGN_MASK) != '0);
        request  = bus.read_en | bus.write_en;
        access   = (state_q == StBusy) && (wait_q == WAIT_W'(1));
    end

    // Next-state, operand latching and ready generation.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_d     = wait_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        err_d      = err_q;
        wdata_d    = wdata_q;
        ben_d      = ben_q;
        ready      = 1'b0;
        unique case (state_q)
            StInit: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = StIdle;
            end
            StIdle: begin
                ready = ~request;
                if (request) begin
                    op_write_d = bus.write_en;
                    idx_d      = word_off[IDX_W-1:0];
                    err_d      = bad_addr;
                    wdata_d    = bus.write_data;
                    ben_d      = bus.byte_en;
                    wait_d     = WAIT_W'(WAIT_CYCLES);
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                wait_d = wait_q - 1'b1;
                if (wait_q == WAIT_W'(1)) state_d = StDone;
            end
            StDone: begin
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    // Control and operand registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            wait_q     <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            ben_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_q     <= wait_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            wdata_q    <= wdata_d;
            ben_q      <= ben_d;
        end
    end

    // Storage: clearing sweep during init, byte-lane write on the completing edge.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[init_cnt_q] <= '0;
        end else if (access && op_write_q && !err_q) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (ben_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    // Read result and error flag; read_data only moves on a completed read or a bad access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q  <= '0;
            addr_error_q <= 1'b0;
        end else if (access) begin
            if (err_q) begin
                read_data_q  <= '0;
                addr_error_q <= 1'b1;
            end else if (!op_write_q) begin
                read_data_q  <= mem[idx_q];
            end
        end else if (state_q == StDone) begin
            addr_error_q <= 1'b0;
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.ready      = ready;
    assign bus.addr_error = addr_error_q;
endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench for param_data_memory with default parameters.
module tb_param_data_memory;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    param_data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    param_data_memory #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH_WORDS(1024),
        .BASE_ADDR  (1024),
        .WAIT_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Counts negedges with ready low from the current negedge on; caller sits on a negedge.
    task automatic wait_sweep(output int cnt);
        cnt = 0;
        #1;
        while (!bus.ready && cnt < 3000) begin
            cnt++;
            @(negedge clk);
            #1;
        end
    endtask

    // One access: present at a negedge, hold until ready, sample DONE outputs, release.
    task automatic do_access(input logic we, input logic re, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] be,
                             output int lat, output logic [31:0] rd, output logic err);
        @(negedge clk);
        bus.write_en   = we;
        bus.read_en    = re;
        bus.address    = addr;
        bus.write_data = wd;
        bus.byte_en    = be;
        lat = 0;
        #1;
        while (!bus.ready && lat < 50) begin
            @(negedge clk);
            #1;
            lat++;
        end
        if (lat >= 50) check("access_timeout", 32'd1, 32'd0);
        rd  = bus.read_data;
        err = bus.addr_error;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
    endtask

    int          lat;
    int          cnt;
    logic [31:0] rd;
    logic        err;

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.read_en    = 1'b0;
        bus.write_en   = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        bus.byte_en    = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_read_data", bus.read_data, 32'h0);
        check("rst_addr_error", 32'(bus.addr_error), 32'd0);
        rst_n = 1'b1;
        wait_sweep(cnt);
        check("sweep_len", 32'(cnt), 32'd1024);

        // Latency and basic write/read.
        do_access(1'b1, 1'b0, 32'h400, 32'h12345678, 4'hF, lat, rd, err);
        check("wr_latency", 32'(lat), 32'd3);
        check("wr_err", 32'(err), 32'd0);
        do_access(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, lat, rd, err);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_400", rd, 32'h12345678);

        // Byte lanes.
        do_access(1'b1, 1'b0, 32'h404, 32'hAABBCCDD, 4'hF, lat, rd, err);
        do_access(1'b1, 1'b0, 32'h404, 32'h11223344, 4'b0101, lat, rd, err);
        do_access(1'b0, 1'b1, 32'h404, 32'h0, 4'h0, lat, rd, err);
        check("byte_lanes", rd, 32'hAA22CC44);

        // Below base: error and zero read data in DONE, flag clears afterwards.
        do_access(1'b0, 1'b1, 32'h3FC, 32'h0, 4'h0, lat, rd, err);
        check("below_err", 32'(err), 32'd1);
        check("below_rd", rd, 32'h0);
        @(negedge clk);
        #1;
        check("err_clear", 32'(bus.addr_error), 32'd0);

        // Past the end: idx 1024 must not alias onto word 0.
        do_access(1'b1, 1'b0, 32'h1400, 32'hCAFEF00D, 4'hF, lat, rd, err);
        check("oor_err", 32'(err), 32'd1);
        do_access(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, lat, rd, err);
        check("oor_nowrite", rd, 32'h12345678);

        // Misaligned write.
        do_access(1'b1, 1'b0, 32'h402, 32'hFFFFFFFF, 4'hF, lat, rd, err);
        check("misalign_err", 32'(err), 32'd1);
        do_access(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, lat, rd, err);
        check("misalign_nowrite", rd, 32'h12345678);

        // Write wins over read; read_data holds across the write.
        do_access(1'b1, 1'b1, 32'h408, 32'h5, 4'hF, lat, rd, err);
        check("both_hold_rd", rd, 32'h12345678);
        do_access(1'b0, 1'b1, 32'h408, 32'h0, 4'h0, lat, rd, err);
        check("both_is_write", rd, 32'h5);

        // Zero byte enables leave the word alone.
        do_access(1'b1, 1'b0, 32'h408, 32'hFFFFFFFF, 4'h0, lat, rd, err);
        check("ben0_err", 32'(err), 32'd0);
        do_access(1'b0, 1'b1, 32'h408, 32'h0, 4'h0, lat, rd, err);
        check("ben0_nowrite", rd, 32'h5);

        // Preload word 5, then reset during BUSY of a write.
        do_access(1'b1, 1'b0, 32'h414, 32'hDEADBEEF, 4'hF, lat, rd, err);
        do_access(1'b0, 1'b1, 32'h414, 32'h0, 4'h0, lat, rd, err);
        check("preload", rd, 32'hDEADBEEF);
        @(negedge clk);
        bus.write_en   = 1'b1;
        bus.address    = 32'h40C;
        bus.write_data = 32'hFFFFFFFF;
        bus.byte_en    = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.ready), 32'd0);
        check("midrst_rd", bus.read_data, 32'h0);
        @(negedge clk);
        bus.write_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_sweep(cnt);
        check("sweep2_len", 32'(cnt), 32'd1024);
        do_access(1'b0, 1'b1, 32'h40C, 32'h0, 4'h0, lat, rd, err);
        check("midrst_word", rd, 32'h0);
        do_access(1'b0, 1'b1, 32'h414, 32'h0, 4'h0, lat, rd, err);
        check("sweep_cleared", rd, 32'h0);
        do_access(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, lat, rd, err);
        check("sweep_cleared0", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
